// File: rtl/fetch_queue_if.sv
// Fetch front-end bundle: instruction-port request/response toward the memory
// wrapper plus the valid/ready head handshake toward decode.
interface fetch_queue_if;
  logic        MEM_RDEN1;
  logic [13:0] MEM_ADDR1;
  logic [31:0] MEM_DOUT1;
  logic        memValid1;
  logic        INSTR_VALID;
  logic [31:0] INSTR;
  logic [31:0] INSTR_PC;
  logic        INSTR_READY;

  modport master (
    output MEM_RDEN1, MEM_ADDR1, INSTR_VALID, INSTR, INSTR_PC,
    input  MEM_DOUT1, memValid1, INSTR_READY
  );
  modport slave (
    input  MEM_RDEN1, MEM_ADDR1, INSTR_VALID, INSTR, INSTR_PC,
    output MEM_DOUT1, memValid1, INSTR_READY
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch front end: sequential word fetch with held requests,
// PC-tagged FIFO toward decode, redirect draining and out-of-range fault.
module fetch_queue #(
  parameter int unsigned DEPTH      = 4,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] IMEM_LIMIT = 32'h0000_6000
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          REDIRECT,
  input  logic [31:0]   REDIRECT_PC,
  output logic          FETCH_FAULT,
  fetch_queue_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {FETCH, DRAIN, FAULT} state_e;
  typedef struct packed {
    logic [31:0] instr;
    logic [13:0] waddr;
  } entry_t;

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d, tgt_q, tgt_d;
  logic          rden_q, rden_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [AW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  entry_t        fifo_q [DEPTH];
  logic          fire, hold, push, pop;
  logic [31:0]   redir_pc;

  assign redir_pc = REDIRECT_PC & ~32'h3;
  assign fire     = rden_q & bus.memValid1;
  assign hold     = rden_q & ~bus.memValid1;
  assign pop      = (cnt_q != '0) & bus.INSTR_READY;
  assign push     = fire & (state_q == FETCH) & ~REDIRECT;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    rden_d  = 1'b0;
    cnt_d   = cnt_q;
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    if (REDIRECT) begin
      cnt_d  = '0;
      rptr_d = '0;
      wptr_d = '0;
      // An in-flight fill cannot be aborted: park the target until it lands.
      if (hold) begin
        state_d = DRAIN;
        tgt_d   = redir_pc;
        rden_d  = 1'b1;
      end else begin
        state_d = FETCH;
        pc_d    = redir_pc;
      end
    end else begin
      if (pop) rptr_d = rptr_q + AW'(1);
      if (push) begin
        wptr_d = wptr_q + AW'(1);
        pc_d   = pc_q + 32'd4;
      end
      cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
      case (state_q)
        FETCH: rden_d = hold;
        DRAIN: begin
          rden_d = hold;
          if (fire) begin
            state_d = FETCH;
            pc_d    = tgt_q;
          end
        end
        default: rden_d = 1'b0;
      endcase
    end
    // Issue decision uses next-cycle occupancy so a push can never hit a full FIFO.
    if (state_d == FETCH && !rden_d) begin
      rden_d = (cnt_d < FULL) && (pc_d < IMEM_LIMIT);
      if (pc_d >= IMEM_LIMIT) state_d = FAULT;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      tgt_q   <= RESET_PC;
      rden_q  <= 1'b0;
      cnt_q   <= '0;
      rptr_q  <= '0;
      wptr_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      rden_q  <= rden_d;
      cnt_q   <= cnt_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) fifo_q[wptr_q] <= '{instr: bus.MEM_DOUT1, waddr: pc_q[15:2]};
  end

  assign bus.MEM_RDEN1   = rden_q;
  assign bus.MEM_ADDR1   = pc_q[15:2];
  assign bus.INSTR_VALID = (cnt_q != '0);
  assign bus.INSTR       = fifo_q[rptr_q].instr;
  assign bus.INSTR_PC    = {16'h0, fifo_q[rptr_q].waddr, 2'b00};
  assign FETCH_FAULT     = (state_q == FAULT) && (cnt_q == '0);
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: memory responder with controllable latency and a
// queue-based model of the expected decode stream.
module tb_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] LIMIT    = 32'h0000_6000;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  logic        CLK, RST_N, REDIRECT, FETCH_FAULT;
  logic [31:0] REDIRECT_PC;
  fetch_queue_if bus();

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .IMEM_LIMIT(LIMIT)) dut (
    .CLK(CLK), .RST_N(RST_N), .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC),
    .FETCH_FAULT(FETCH_FAULT), .bus(bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int          checks, errors;
  entry_t      q[$];
  logic [31:0] popped[$];
  logic [31:0] m_pc;
  bit          drain, held, first, last_rd;
  logic [13:0] prev_a, last_a, miss_addr;
  int          wait_cnt, rnd_lat, mode, miss_lat, n_hs;

  function automatic logic [31:0] instr_of(input logic [13:0] a);
    return {a, 18'h0} ^ {18'h0, a} ^ 32'hA5C3_0F00;
  endfunction

  // One clock: check DUT state against the model, drive inputs, advance the model.
  task automatic cycle(input bit redir, input logic [31:0] rpc, input bit rdy);
    logic rd, vld;
    logic [13:0] a;
    int lat;
    bit pop, hs, exp_rd, exp_flt;
    entry_t e;
    @(negedge CLK);
    rd = bus.MEM_RDEN1;
    a  = bus.MEM_ADDR1;
    checks++;
    if (held) begin
      if (rd !== 1'b1 || a !== prev_a) begin
        errors++;
        $display("FAIL hold: rden=%0b addr=%h, required rden=1 addr=%h", rd, a, prev_a);
      end
    end else begin
      exp_rd = !first && q.size() < DEPTH && m_pc < LIMIT;
      if (rd !== exp_rd) begin
        errors++;
        $display("FAIL rden: got %0b, required %0b (pc=%h occ=%0d)", rd, exp_rd, m_pc, q.size());
      end
      if (rd === 1'b1) begin
        checks++;
        if (a !== m_pc[15:2]) begin
          errors++;
          $display("FAIL addr: got %h, required %h", a, m_pc[15:2]);
        end
      end
    end
    checks++;
    if (bus.INSTR_VALID !== (q.size() != 0)) begin
      errors++;
      $display("FAIL instr_valid: got %0b, required %0b", bus.INSTR_VALID, q.size() != 0);
    end
    if (q.size() != 0) begin
      checks++;
      if (bus.INSTR !== q[0].instr || bus.INSTR_PC !== q[0].pc) begin
        errors++;
        $display("FAIL head: got %h@%h, required %h@%h", bus.INSTR, bus.INSTR_PC, q[0].instr, q[0].pc);
      end
    end
    exp_flt = m_pc >= LIMIT && q.size() == 0 && !drain;
    checks++;
    if (FETCH_FAULT !== exp_flt) begin
      errors++;
      $display("FAIL fetch_fault: got %0b, required %0b (pc=%h)", FETCH_FAULT, exp_flt, m_pc);
    end

    lat = (mode == 2 && a == miss_addr) ? miss_lat : (mode == 1 ? rnd_lat : 0);
    vld = rd && (wait_cnt >= lat);
    bus.memValid1   = vld;
    bus.MEM_DOUT1   = instr_of(a);
    bus.INSTR_READY = rdy;
    REDIRECT        = redir;
    REDIRECT_PC     = rpc;
    hs  = rd && vld;
    pop = q.size() != 0 && rdy;
    if (redir) begin
      q.delete();
      drain = rd && !vld;
      m_pc  = rpc & ~32'h3;
    end else begin
      if (pop) begin
        popped.push_back(bus.INSTR_PC);
        void'(q.pop_front());
      end
      if (hs) begin
        if (drain) drain = 0;
        else begin
          e.instr = instr_of(a);
          e.pc    = m_pc;
          q.push_back(e);
          m_pc += 32'd4;
        end
      end
    end
    if (hs || !rd) begin
      wait_cnt = 0;
      if (hs) rnd_lat = $urandom_range(0, 3);
    end else wait_cnt++;
    if (hs) n_hs++;
    held    = rd && !vld;
    prev_a  = a;
    last_rd = rd;
    last_a  = a;
    first   = 0;
  endtask

  task automatic reset_on();
    #2 RST_N = 1'b0;
    REDIRECT = 1'b0;
    REDIRECT_PC = '0;
    bus.memValid1 = 1'b0;
    bus.MEM_DOUT1 = '0;
    bus.INSTR_READY = 1'b0;
  endtask

  task automatic reset_off();
    repeat (2) @(posedge CLK);
    #2 RST_N = 1'b1;
    q.delete();
    popped.delete();
    m_pc = RESET_PC; drain = 0; held = 0; first = 1;
    wait_cnt = 0; rnd_lat = 0; n_hs = 0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    reset_on();
    reset_off();
  endtask

  task automatic test_reset();
    @(negedge CLK);
    reset_on();
    #1;
    checks++;
    if (bus.MEM_RDEN1 !== 1'b0 || bus.INSTR_VALID !== 1'b0 || FETCH_FAULT !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: rden=%0b valid=%0b fault=%0b, required 0 0 0",
               bus.MEM_RDEN1, bus.INSTR_VALID, FETCH_FAULT);
    end
    checks++;
    if (bus.MEM_ADDR1 !== RESET_PC[15:2]) begin
      errors++;
      $display("FAIL reset_addr: got %h, required %h", bus.MEM_ADDR1, RESET_PC[15:2]);
    end
    reset_off();
  endtask

  task automatic test_all_hit();
    bit ok;
    do_reset();
    mode = 0;
    repeat (20) cycle(0, '0, 1);
    checks++;
    if (n_hs != 19) begin
      errors++;
      $display("FAIL all_hit_rate: handshakes %0d, required 19", n_hs);
    end
    ok = popped.size() == 18;
    foreach (popped[i]) if (popped[i] !== 32'(i * 4)) ok = 0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL all_hit_order: %0d pops, first pc %h, required 18 pops from 0", popped.size(),
               popped.size() ? popped[0] : 32'hx);
    end
  endtask

  task automatic test_miss();
    int cnt4, n10;
    do_reset();
    mode = 2; miss_addr = 14'h004; miss_lat = 10;
    cnt4 = 0;
    repeat (25) begin
      cycle(0, '0, 1);
      if (last_rd && last_a == 14'h004) cnt4++;
    end
    n10 = 0;
    foreach (popped[i]) if (popped[i] == 32'h10) n10++;
    checks++;
    if (cnt4 != 11) begin
      errors++;
      $display("FAIL miss_stable: addr 0x004 held %0d cycles, required 11", cnt4);
    end
    checks++;
    if (n10 != 1) begin
      errors++;
      $display("FAIL miss_push: pc 0x10 delivered %0d times, required 1", n10);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    mode = 0;
    repeat (10) cycle(0, '0, 0);
    checks++;
    if (n_hs != DEPTH || last_rd !== 1'b0) begin
      errors++;
      $display("FAIL bp_fill: handshakes %0d rden %0b, required %0d and 0", n_hs, last_rd, DEPTH);
    end
    cycle(0, '0, 1);
    repeat (6) cycle(0, '0, 0);
    checks++;
    if (n_hs != DEPTH + 1 || last_rd !== 1'b0) begin
      errors++;
      $display("FAIL bp_refill: handshakes %0d rden %0b, required %0d and 0", n_hs, last_rd, DEPTH + 1);
    end
  endtask

  task automatic test_redirect_miss();
    int cnt5;
    logic [13:0] first_new;
    bit got_new;
    do_reset();
    mode = 2; miss_addr = 14'h005; miss_lat = 6;
    for (int i = 0; i < 20; i++) begin
      cycle(0, '0, 1);
      if (last_rd && last_a == 14'h005) break;
    end
    cnt5 = 1;
    popped.delete();
    cycle(1, 32'h0000_0203, 1);
    if (last_rd && last_a == 14'h005) cnt5++;
    got_new = 0; first_new = '0;
    repeat (15) begin
      cycle(0, '0, 1);
      if (last_rd && last_a == 14'h005) cnt5++;
      else if (last_rd && !got_new) begin
        got_new = 1;
        first_new = last_a;
      end
    end
    checks++;
    if (cnt5 != 7) begin
      errors++;
      $display("FAIL drain_hold: addr 0x005 held %0d cycles, required 7", cnt5);
    end
    checks++;
    if (!got_new || first_new !== 14'h080) begin
      errors++;
      $display("FAIL drain_target: next addr %h, required 080", first_new);
    end
    checks++;
    if (popped.size() == 0 || popped[0] !== 32'h200) begin
      errors++;
      $display("FAIL drain_first_pc: got %h, required 00000200", popped.size() ? popped[0] : 32'hx);
    end
  endtask

  task automatic test_fault();
    do_reset();
    mode = 0;
    cycle(1, 32'h0000_5FFC, 1);
    popped.delete();
    repeat (6) cycle(0, '0, 1);
    checks++;
    if (popped.size() != 1 || popped[0] !== 32'h5FFC) begin
      errors++;
      $display("FAIL fault_last: %0d pops, first %h, required 1 pop of 00005ffc", popped.size(),
               popped.size() ? popped[0] : 32'hx);
    end
    checks++;
    if (FETCH_FAULT !== 1'b1 || bus.MEM_RDEN1 !== 1'b0) begin
      errors++;
      $display("FAIL fault_flag: fault=%0b rden=%0b, required 1 0", FETCH_FAULT, bus.MEM_RDEN1);
    end
    cycle(1, 32'h0000_0100, 1);
    cycle(0, '0, 1);
    checks++;
    if (FETCH_FAULT !== 1'b0 || !last_rd || last_a !== 14'h040) begin
      errors++;
      $display("FAIL fault_exit: fault=%0b rden=%0b addr=%h, required 0 1 040", FETCH_FAULT, last_rd, last_a);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    mode = 2; miss_addr = 14'h002; miss_lat = 8;
    repeat (7) cycle(0, '0, 0);
    checks++;
    if (bus.INSTR_VALID !== 1'b1 || bus.MEM_RDEN1 !== 1'b1) begin
      errors++;
      $display("FAIL arst_setup: valid=%0b rden=%0b, required 1 1", bus.INSTR_VALID, bus.MEM_RDEN1);
    end
    reset_on();
    #1;
    checks++;
    if (bus.INSTR_VALID !== 1'b0 || bus.MEM_RDEN1 !== 1'b0) begin
      errors++;
      $display("FAIL arst_immediate: valid=%0b rden=%0b, required 0 0", bus.INSTR_VALID, bus.MEM_RDEN1);
    end
    reset_off();
    mode = 0;
    repeat (2) cycle(0, '0, 1);
    checks++;
    if (!last_rd || last_a !== RESET_PC[15:2]) begin
      errors++;
      $display("FAIL arst_restart: rden=%0b addr=%h, required 1 %h", last_rd, last_a, RESET_PC[15:2]);
    end
  endtask

  task automatic test_random();
    bit redir;
    logic [31:0] rpc;
    do_reset();
    mode = 1;
    repeat (800) begin
      redir = $urandom_range(0, 39) == 0;
      rpc = ($urandom_range(0, 3) == 0) ? 32'h5FE0 + $urandom_range(0, 63)
                                        : 32'($urandom_range(0, 32'h6010));
      cycle(redir, rpc, $urandom_range(0, 3) != 0);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    RST_N = 1'b0;
    REDIRECT = 1'b0; REDIRECT_PC = '0;
    bus.memValid1 = 1'b0; bus.MEM_DOUT1 = '0; bus.INSTR_READY = 1'b0;
    mode = 0; miss_addr = '0; miss_lat = 0;
    test_reset();
    test_all_hit();
    test_miss();
    test_backpressure();
    test_redirect_miss();
    test_fault();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL timeout: simulation exceeded 300000 time units");
    $fatal(1);
  end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction-fetch front end sitting directly upstream of the two-level memory wrapper's instruction port.
- Generates sequential word addresses on MEM_ADDR1 and holds each request until memValid1, tolerating both single-cycle L1 hits and multi-cycle line fills.
- Buffers returned instructions with their PCs in a small FIFO for decode, using a valid/ready handshake.
- Handles pipeline redirects (branch/jump) and flags fetches beyond the instruction region.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- RESET_PC, 32'h0000_0000, first fetch byte address after reset.
- IMEM_LIMIT, 32'h0000_6000, first byte address outside instruction space.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- REDIRECT  in  1  flush and restart fetch at REDIRECT_PC.
- REDIRECT_PC  in  32  new fetch byte address; bits [1:0] ignored.
- MEM_RDEN1  out  1  instruction read request to memory wrapper.
- MEM_ADDR1  out  14  word address, equal to PC[15:2].
- MEM_DOUT1  in  32  instruction from memory wrapper.
- memValid1  in  1  MEM_DOUT1 valid this cycle; may be high in the same cycle MEM_RDEN1 rises (hit).
- INSTR_VALID  out  1  FIFO head valid.
- INSTR  out  32  head instruction.
- INSTR_PC  out  32  head byte address.
- INSTR_READY  in  1  decode accepts head when INSTR_VALID=1.
- FETCH_FAULT  out  1  fetch PC reached IMEM_LIMIT with FIFO empty.

Behaviour:
- Reset (async assert):
  - MEM_RDEN1=0, INSTR_VALID=0, FETCH_FAULT=0, FIFO count=0, pointers=0.
  - PC=RESET_PC, state=FETCH.
  - MEM_ADDR1 = RESET_PC[15:2].
  - Reset mid-miss abandons the request; the memory wrapper is reset with the core.
- FETCH state:
  - MEM_RDEN1=1 when count<DEPTH and PC<IMEM_LIMIT; otherwise 0.
  - MEM_ADDR1 stays stable while MEM_RDEN1=1 and memValid1=0.
  - At an edge with MEM_RDEN1&memValid1: push {MEM_DOUT1, PC}, then PC+=4.
  - Back-to-back hits give one instruction per cycle.
- Request rule:
  - Once MEM_RDEN1=1 is presented, it and MEM_ADDR1 are held until memValid1, even if the FIFO becomes full or REDIRECT arrives. The cache controller cannot abort a fill.
- Push/pop:
  - Pop on INSTR_VALID&INSTR_READY.
  - Simultaneous push and pop leaves count unchanged.
  - Push when full cannot occur, because requests are gated on count<DEPTH at issue.
  - Read/write pointers wrap modulo DEPTH.
  - INSTR/INSTR_PC come from a registered head, no combinational path from memory.
- REDIRECT (sampled at edge, has priority over push/pop):
  - FIFO flushed: INSTR_VALID=0 the next cycle.
  - PC=REDIRECT_PC with [1:0] forced to 0; FETCH_FAULT cleared.
  - If no request is outstanding (MEM_RDEN1=0, or memValid1=1 that cycle): go to FETCH; the same-cycle response is discarded.
  - If a request is outstanding without memValid1: go to DRAIN and latch the target.
- DRAIN state:
  - Keep MEM_RDEN1=1 with the old MEM_ADDR1 until memValid1; discard the data.
  - Then go to FETCH at the latched PC.
  - A further REDIRECT in DRAIN overwrites the latched PC and stays in DRAIN.
- FAULT state:
  - Entered from FETCH when PC>=IMEM_LIMIT and no request is outstanding.
  - MEM_RDEN1=0.
  - Remaining FIFO entries still drain to decode.
  - FETCH_FAULT=1 once count=0.
  - Exit only by REDIRECT, or by reset.
- Sequential PC wrap:
  - A PC increment that reaches IMEM_LIMIT leads to FAULT, never wraps to 0.
  - 14-bit MEM_ADDR1 never aliases.
- INSTR_PC = {16'h0, PC[15:2], 2'b00}.

Test Plan:
- All-hit stream: reset with memValid1 tied to MEM_RDEN1, INSTR_READY=1 -> addresses 0x000,0x001,0x002... one per cycle; INSTR_PC 0x0,0x4,0x8 in order, no gaps.
- Miss latency: memValid1 delayed 10 cycles on addr 0x004 -> MEM_ADDR1 stable at 0x004 for 11 cycles; exactly one push with PC 0x10.
- Backpressure: INSTR_READY=0, hits -> exactly DEPTH=4 entries pushed, then MEM_RDEN1=0. One pop -> exactly one new request issued.
- Redirect during miss: REDIRECT_PC=0x0203 while addr 0x005 is pending -> MEM_RDEN1 held on 0x005 until memValid1, its data dropped; next request addr 0x080, INSTR_PC 0x200.
- Fault: REDIRECT_PC=0x5FFC, all hits -> one instruction at PC 0x5FFC, then MEM_RDEN1=0 and FETCH_FAULT=1 after drain. REDIRECT_PC=0x100 -> FETCH_FAULT=0, fetch resumes at addr 0x040.
- Async reset mid-miss: RST_N low between edges -> MEM_RDEN1 and INSTR_VALID low immediately. After release, first request is addr RESET_PC[15:2].
